// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: instruction-memory port pair, fetch/redirect
// control and the two-slot decode handoff.
interface fetch_ctrl_if;
    logic [31:0] imem_addr0;
    logic [31:0] imem_addr1;
    logic [31:0] imem_inst0;
    logic [31:0] imem_inst1;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid0;
    logic        dec_valid1;
    logic [31:0] dec_inst0;
    logic [31:0] dec_inst1;
    logic [31:0] dec_pc0;
    logic [31:0] dec_pc1;
    logic [1:0]  dec_take;

    // The fetch controller side.
    modport master (
        output imem_addr0, imem_addr1,
        input  imem_inst0, imem_inst1,
        input  fetch_en, redirect_valid, redirect_pc,
        output dec_valid0, dec_valid1, dec_inst0, dec_inst1, dec_pc0, dec_pc1,
        input  dec_take
    );

    // Memory, branch unit and issue stage as seen from outside the controller.
    modport slave (
        input  imem_addr0, imem_addr1,
        output imem_inst0, imem_inst1,
        output fetch_en, redirect_valid, redirect_pc,
        input  dec_valid0, dec_valid1, dec_inst0, dec_inst1, dec_pc0, dec_pc1,
        output dec_take
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch controller: fetches a word pair per cycle into a 4-entry
// circular buffer and hands up to two instructions per cycle to issue.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] buf_pc_q   [4];
    logic [31:0] buf_inst_q [4];

    logic [1:0]  take_req;
    logic [2:0]  take_eff;
    logic [2:0]  count_left;
    logic        do_fetch;
    logic [1:0]  head_p1;
    logic [1:0]  tail_p1;
    logic [3:0]  wr0_sel;
    logic [3:0]  wr1_sel;
    logic        unused_rpc_bits;

    // A take of 3 is treated as 2, and nothing beyond what is buffered is consumed.
    always_comb begin
        take_req = 2'd0;
        if (bus.dec_take == 2'd1)
            take_req = 2'd1;
        else if (bus.dec_take[1])
            take_req = 2'd2;
        take_eff   = ({1'b0, take_req} > count_q) ? count_q : {1'b0, take_req};
        count_left = count_q - take_eff;
        do_fetch   = bus.fetch_en & ~bus.redirect_valid & (count_left <= 3'd2);
    end

    assign head_p1 = head_q + 2'd1;
    assign tail_p1 = tail_q + 2'd1;
    assign unused_rpc_bits = ^bus.redirect_pc[1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            head_d     = 2'd0;
            tail_d     = 2'd0;
            count_d    = 3'd0;
        end else begin
            head_d  = head_q + take_eff[1:0];
            count_d = count_left + (do_fetch ? 3'd2 : 3'd0);
            if (do_fetch) begin
                tail_d     = tail_q + 2'd2;
                fetch_pc_d = fetch_pc_q + 32'd8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Per-entry write selects: the first word of a pair lands at tail, the second at tail+1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign wr0_sel[gi] = do_fetch & (tail_q  == 2'(gi));
            assign wr1_sel[gi] = do_fetch & (tail_p1 == 2'(gi));
        end
    endgenerate

    // Payload storage needs no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr0_sel[i]) begin
                buf_pc_q[i]   <= fetch_pc_q;
                buf_inst_q[i] <= bus.imem_inst0;
            end else if (wr1_sel[i]) begin
                buf_pc_q[i]   <= fetch_pc_q + 32'd4;
                buf_inst_q[i] <= bus.imem_inst1;
            end
        end
    end

    assign bus.imem_addr0 = fetch_pc_q;
    assign bus.imem_addr1 = fetch_pc_q + 32'd4;

    always_comb begin
        bus.dec_valid0 = (count_q != 3'd0);
        bus.dec_valid1 = (count_q >= 3'd2);
        bus.dec_inst0  = NOP_INST;
        bus.dec_pc0    = 32'd0;
        bus.dec_inst1  = NOP_INST;
        bus.dec_pc1    = 32'd0;
        if (bus.dec_valid0) begin
            bus.dec_inst0 = buf_inst_q[head_q];
            bus.dec_pc0   = buf_pc_q[head_q];
        end
        if (bus.dec_valid1) begin
            bus.dec_inst1 = buf_inst_q[head_p1];
            bus.dec_pc1   = buf_pc_q[head_p1];
        end
    end
endmodule
